// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/subtract unit.
// Saturation support is enabled by defining ADDSUB_SATURATE_EN.
package addsub_pkg;

  localparam int FLAG_W = 5;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
    logic borrow;
    logic carry;
  } flags_t;

endpackage

// File: rtl/addsub_slice.sv
// One registered SW-bit adder slice of the split carry chain.
// Operand b arrives pre-inverted for subtraction; ci supplies the +1.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] sum_q,
  output logic          co_q
);

  logic [SW-1:0] sum_d;
  logic          co_d;
  logic [SW:0]   full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
    sum_d = sum_q;
    co_d  = co_q;
    if (en) begin
      sum_d = full[SW-1:0];
      co_d  = full[SW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      co_q  <= co_d;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with valid/ready handshake and status flags.
// Define ADDSUB_SATURATE_EN to enable per-beat signed saturation.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic              in_sat,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_res,
  output logic [FLAG_W-1:0] out_flags
);

  localparam int SW = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > 8) begin : g_bad_cfg
    $error("addsub_pipe: bad WIDTH/STAGES");
  end

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] op_q, op_d;
  logic [STAGES-1:0] sat_q, sat_d;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  a_d  [STAGES];
  logic [WIDTH-1:0]  b_q  [STAGES];
  logic [WIDTH-1:0]  b_d  [STAGES];
  logic [WIDTH-1:0]  lo_q [STAGES];
  logic [WIDTH-1:0]  lo_d [STAGES];

  // Index 0 is the input port, index k+1 is stage k's register.
  logic [STAGES:0]   src_v, src_op, src_sat, src_c;
  logic [WIDTH-1:0]  src_a  [STAGES+1];
  logic [WIDTH-1:0]  src_b  [STAGES+1];
  logic [WIDTH-1:0]  src_lo [STAGES+1];

  logic [STAGES:0]   adv;
  logic [SW-1:0]     sl_a  [STAGES];
  logic [SW-1:0]     sl_b  [STAGES];
  logic [SW-1:0]     sum_w [STAGES];
  logic [WIDTH-1:0]  res_c [STAGES];
  logic [STAGES-1:0] co_w;

  always_comb begin
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !vld_q[k] || adv[k+1];
    end
  end

  assign in_ready = rst_n && adv[0];

  always_comb begin
    src_v[0]   = in_valid;
    src_op[0]  = in_op;
`ifdef ADDSUB_SATURATE_EN
    src_sat[0] = in_sat;
`else
    src_sat[0] = 1'b0;
`endif
    src_c[0]   = in_op;
    src_a[0]   = in_a;
    src_b[0]   = in_b;
    src_lo[0]  = '0;
    for (int k = 0; k < STAGES; k++) begin
      src_v[k+1]   = vld_q[k];
      src_op[k+1]  = op_q[k];
      src_sat[k+1] = sat_q[k];
      src_c[k+1]   = co_w[k];
      src_a[k+1]   = a_q[k];
      src_b[k+1]   = b_q[k];
      src_lo[k+1]  = res_c[k];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sl_a[k]  = src_a[k][k*SW +: SW];
      sl_b[k]  = src_b[k][k*SW +: SW] ^ {SW{src_op[k]}};
      res_c[k] = lo_q[k];
      res_c[k][k*SW +: SW] = sum_w[k];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    addsub_slice #(.SW(SW)) u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv[g]),
      .a     (sl_a[g]),
      .b     (sl_b[g]),
      .ci    (src_c[g]),
      .sum_q (sum_w[g]),
      .co_q  (co_w[g])
    );
  end

  always_comb begin
    vld_d = vld_q;
    op_d  = op_q;
    sat_d = sat_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]  = a_q[k];
      b_d[k]  = b_q[k];
      lo_d[k] = lo_q[k];
      if (adv[k]) begin
        vld_d[k] = src_v[k];
        op_d[k]  = src_op[k];
        sat_d[k] = src_sat[k];
        a_d[k]   = src_a[k];
        b_d[k]   = src_b[k];
        lo_d[k]  = src_lo[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      op_q  <= '0;
      sat_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        lo_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      op_q  <= op_d;
      sat_q <= sat_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= a_d[k];
        b_q[k]  <= b_d[k];
        lo_q[k] <= lo_d[k];
      end
    end
  end

  logic [WIDTH-1:0] res_raw, res_fin;
  logic             am, bm, rm, ovf, is_sub;
  flags_t           fl;

  always_comb begin
    res_raw = src_lo[STAGES];
    is_sub  = (op_e'(src_op[STAGES]) == OP_SUB);
    am      = src_a[STAGES][WIDTH-1];
    bm      = src_b[STAGES][WIDTH-1];
    rm      = res_raw[WIDTH-1];
    ovf     = is_sub ? (am != bm && rm != am)
                     : (am == bm && rm != am);
    res_fin = res_raw;
`ifdef ADDSUB_SATURATE_EN
    // A positive operand a overflowing means the true result was too large.
    if (src_sat[STAGES] && ovf) begin
      res_fin = am ? {1'b1, {(WIDTH-1){1'b0}}}
                   : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    fl.ovf    = ovf;
    fl.neg    = res_fin[WIDTH-1];
    fl.zero   = (res_fin == '0);
    fl.borrow = is_sub && !src_c[STAGES];
    fl.carry  = !is_sub && src_c[STAGES];
  end

`ifndef ADDSUB_SATURATE_EN
  logic sat_unused;
  assign sat_unused = in_sat ^ src_sat[STAGES];
`endif

  assign out_valid = src_v[STAGES];
  assign out_res   = out_valid ? res_fin : '0;
  assign out_flags = out_valid ? fl : '0;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (32/2 main, plus 8/4 and 64/1 corners).
// Saturation expectations follow ADDSUB_SATURATE_EN.
module tb_addsub_pipe;
  import addsub_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_op, in_sat;
  logic [31:0] in_a, in_b, out_res;
  logic        out_valid, out_ready;
  logic [4:0]  out_flags;

  addsub_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_sat(in_sat),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_flags(out_flags)
  );

  logic       v8, r8, ov8;
  logic [7:0] res8;
  logic [4:0] f8;

  addsub_pipe #(.WIDTH(8), .STAGES(4)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(r8),
    .in_op(1'b0), .in_sat(1'b0),
    .in_a(8'hFF), .in_b(8'h01),
    .out_valid(ov8), .out_ready(1'b1),
    .out_res(res8), .out_flags(f8)
  );

  logic        v64, r64, ov64;
  logic [63:0] res64;
  logic [4:0]  f64;

  addsub_pipe #(.WIDTH(64), .STAGES(1)) u64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v64), .in_ready(r64),
    .in_op(1'b0), .in_sat(1'b0),
    .in_a(64'hFFFF_FFFF_FFFF_FFFF), .in_b(64'h1),
    .out_valid(ov64), .out_ready(1'b1),
    .out_res(res64), .out_flags(f64)
  );

  typedef struct {
    logic        op;
    logic        sat;
    logic [31:0] a, b, res;
    logic [4:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  f;
    int          cyc;
    bit          lat;
    bit          seen;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0, n_cmp = 0, errs = 0, cyc = 0;
  bit   tog = 1'b0;
  logic ordy_fix, ordy_rnd;

  assign out_ready = tog ? ordy_rnd : ordy_fix;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 ordy_rnd = 1'($urandom_range(0, 1));
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: outputs must match the head entry every cycle they are shown.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        errs++;
        $display("FAIL stale: res %h with empty scoreboard", out_res);
      end else begin
        n_cmp++;
        if (out_res !== sb[0].res || out_flags !== sb[0].f) begin
          errs++;
          $display("FAIL beat%0d: res %h flags %b want %h %b",
                   sb[0].id, out_res, out_flags, sb[0].res, sb[0].f);
        end
        if (sb[0].lat && !sb[0].seen) begin
          n_cmp++;
          if (cyc - sb[0].cyc != 2) begin
            errs++;
            $display("FAIL latency beat%0d: got %0d want 2",
                     sb[0].id, cyc - sb[0].cyc);
          end
        end
        sb[0].seen = 1'b1;
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic addv(logic op, logic sat, logic [31:0] a, logic [31:0] b,
                      logic [31:0] res, logic [4:0] f);
    vec_t v;
    v.op = op; v.sat = sat; v.a = a; v.b = b; v.res = res; v.f = f;
    vecs.push_back(v);
  endtask

  task automatic send(vec_t v, bit lat);
    exp_t e;
    bit   acc;
    int   w;
    in_valid = 1'b1;
    in_op    = v.op;
    in_sat   = v.sat;
    in_a     = v.a;
    in_b     = v.b;
    acc = 1'b0;
    w = 0;
    while (!acc && w < 200) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = v.res; e.f = v.f; e.cyc = cyc;
        e.lat = lat; e.seen = 1'b0; e.id = n_vec;
        sb.push_back(e);
        n_vec++;
        acc = 1'b1;
      end
      w++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      errs++;
      $display("FAIL accept timeout: in_ready %b want 1", in_ready);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d beats pending want 0", sb.size());
    end
    #1;
  endtask

  initial begin
    int t0, w;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_sat = 1'b0;
    in_a = '0; in_b = '0; ordy_fix = 1'b1; v8 = 1'b0; v64 = 1'b0;

    // {ovf, neg, zero, borrow, carry}
    addv(0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b11000);
    addv(1, 0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 5'b01010);
    addv(1, 0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 5'b00100);
    addv(0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b00101);
    addv(0, 0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 5'b00000);
    addv(1, 0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b10000);
    addv(1, 0, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 5'b01010);
    addv(1, 0, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 5'b00000);
    addv(0, 0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 5'b00000);
    addv(1, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 5'b11010);
    addv(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'b01001);
    addv(0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 5'b00100);
    addv(1, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 5'b01000);
    addv(0, 0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 5'b00000);
    addv(1, 0, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 5'b00000);
`ifdef ADDSUB_SATURATE_EN
    addv(1, 1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 5'b11000);
    addv(0, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'b10000);
`else
    addv(1, 1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b10000);
    addv(0, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 5'b11000);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_res", 64'(out_res), 64'd0);
    chk("rst out_flags", 64'(out_flags), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) send(vecs[i], 1'b1);
    drain();

    tog = 1'b1;
    foreach (vecs[i]) send(vecs[i], 1'b0);
    drain();
    tog = 1'b0;

    // Fill the pipe while stalled, then reset mid-flight.
    ordy_fix = 1'b0;
    send(vecs[0], 1'b0);
    send(vecs[1], 1'b0);
    @(negedge clk);
    chk("full in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("in-rst in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ordy_fix = 1'b1;
    @(negedge clk);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    send(vecs[2], 1'b1);
    drain();

    // W=8, S=4 corner.
    @(posedge clk);
    #1 v8 = 1'b1;
    @(negedge clk);
    n_vec++;
    chk("u8 in_ready", 64'(r8), 64'd1);
    t0 = cyc;
    @(posedge clk);
    #1 v8 = 1'b0;
    w = 0;
    while (!ov8 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("u8 out_valid", 64'(ov8), 64'd1);
    chk("u8 latency", 64'(cyc - t0), 64'd4);
    chk("u8 res", 64'(res8), 64'h00);
    chk("u8 flags", 64'(f8), 64'(5'b00101));

    // W=64, S=1 corner.
    @(posedge clk);
    #1 v64 = 1'b1;
    @(negedge clk);
    n_vec++;
    chk("u64 in_ready", 64'(r64), 64'd1);
    t0 = cyc;
    @(posedge clk);
    #1 v64 = 1'b0;
    w = 0;
    while (!ov64 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("u64 out_valid", 64'(ov64), 64'd1);
    chk("u64 latency", 64'(cyc - t0), 64'd1);
    chk("u64 res", res64, 64'h0);
    chk("u64 flags", 64'(f64), 64'(5'b00101));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
    $finish;
  end

endmodule
